// File: rtl/mem_wb_stage_pkg.sv
// Shared defines for the MEM->WB stage: load-op encodings and common constants.
// Combinational constants only; no latency, no backpressure.
package mem_wb_stage_pkg;

    localparam logic       RstEnable    = 1'b1;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [2:0] LOAD_NONE = 3'b000;
    localparam logic [2:0] LOAD_LB   = 3'b001;
    localparam logic [2:0] LOAD_LBU  = 3'b010;
    localparam logic [2:0] LOAD_LH   = 3'b011;
    localparam logic [2:0] LOAD_LHU  = 3'b100;
    localparam logic [2:0] LOAD_LW   = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load formatter: byte/halfword extract, sign/zero extend, misalign detect.
// Purely combinational (zero latency); no backpressure.
// Non-load ops pass wdata through untouched.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    load_op,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] fmt_data,
    output logic          misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'b00:   byte_sel = rdata[DW-1 -: 8];
            2'b01:   byte_sel = rdata[DW-9 -: 8];
            2'b10:   byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[15:0] : rdata[DW-1 -: 16];
    end

    always_comb begin
        fmt_data = wdata;
        misalign = 1'b0;
        case (load_op)
            LOAD_NONE: fmt_data = wdata;
            LOAD_LB:   fmt_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU:  fmt_data = {{(DW-8){1'b0}}, byte_sel};
            LOAD_LH: begin
                fmt_data = {{(DW-16){half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LOAD_LHU: begin
                fmt_data = {{(DW-16){1'b0}}, half_sel};
                misalign = addr_lo[0];
            end
            LOAD_LW: begin
                fmt_data = rdata;
                misalign = (addr_lo != 2'b00);
            end
            default:   fmt_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register feeding the register file write port; optional HI/LO pair (WB_HILO_EN).
// Latency: one cycle MEM->WB; HI/LO architectural regs update one cycle after WB, bypassed meanwhile.
// Backpressure: stall_mem && !stall_wb inserts a bubble, both stalls hold every register; flush kills.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_mem,
    input  logic          stall_wb,
    input  logic          flush,
    input  logic [AW-1:0] mem_wd,
    input  logic          mem_wreg,
    input  logic [DW-1:0] mem_wdata,
    input  logic [2:0]    mem_load_op,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_whilo,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    output logic [AW-1:0] wb_wd,
    output logic          wb_wreg,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_adel,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0] fmt_data;
    logic          misalign;

    load_align #(.DW(DW)) u_load_align (
        .load_op  (mem_load_op),
        .addr_lo  (mem_addr_lo),
        .rdata    (mem_rdata),
        .wdata    (mem_wdata),
        .fmt_data (fmt_data),
        .misalign (misalign)
    );

    logic          bubble;
    logic          capture;
    logic [AW-1:0] wd_d,    wd_q;
    logic          wreg_d,  wreg_q;
    logic [DW-1:0] wdata_d, wdata_q;
    logic          adel_d,  adel_q;

    assign bubble  = flush || (stall_mem && !stall_wb);
    assign capture = !bubble && !stall_mem;

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        adel_d  = adel_q;
        if (bubble) begin
            wd_d    = '0;
            wreg_d  = WriteDisable;
            wdata_d = ZeroWord;
            adel_d  = 1'b0;
        end else if (capture) begin
            // A misaligned load still records its destination so the trap handler can see it.
            wd_d    = mem_wd;
            wreg_d  = misalign ? WriteDisable : (mem_wreg ? WriteEnable : WriteDisable);
            wdata_d = misalign ? ZeroWord : fmt_data;
            adel_d  = misalign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            wd_q    <= '0;
            wreg_q  <= WriteDisable;
            wdata_q <= ZeroWord;
            adel_q  <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            adel_q  <= adel_d;
        end
    end

    assign wb_wd    = wd_q;
    assign wb_wreg  = wreg_q;
    assign wb_wdata = wdata_q;
    assign wb_adel  = adel_q;

`ifdef WB_HILO_EN
    logic          whilo_d, whilo_q;
    logic [DW-1:0] wb_hi_d, wb_hi_q;
    logic [DW-1:0] wb_lo_d, wb_lo_q;
    logic [DW-1:0] hi_d,    hi_q;
    logic [DW-1:0] lo_d,    lo_q;

    always_comb begin
        whilo_d = whilo_q;
        wb_hi_d = wb_hi_q;
        wb_lo_d = wb_lo_q;
        if (bubble) begin
            whilo_d = 1'b0;
            wb_hi_d = ZeroWord;
            wb_lo_d = ZeroWord;
        end else if (capture) begin
            whilo_d = mem_whilo;
            wb_hi_d = mem_hi;
            wb_lo_d = mem_lo;
        end
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo_q && !stall_wb) begin
            hi_d = wb_hi_q;
            lo_d = wb_lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            whilo_q <= 1'b0;
            wb_hi_q <= ZeroWord;
            wb_lo_q <= ZeroWord;
            hi_q    <= ZeroWord;
            lo_q    <= ZeroWord;
        end else begin
            whilo_q <= whilo_d;
            wb_hi_q <= wb_hi_d;
            wb_lo_q <= wb_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Bypass lets an MFHI right behind an MTHI see the value still sitting in WB.
    assign hi_o = whilo_q ? wb_hi_q : hi_q;
    assign lo_o = whilo_q ? wb_lo_q : lo_q;
`else
    logic unused_hilo;
    assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
    assign hi_o = ZeroWord;
    assign lo_o = ZeroWord;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM→WB pipeline register of the 5-stage core; its outputs drive the register file write port (we / write_addr / write_instr).
- Captures MEM-stage results on the rising clock edge. The register file commits on the falling edge of the same cycle.
- Registers and formats load data (byte/halfword extract, sign/zero extend, big-endian) and flags misaligned loads.
- Handles stall bubbles and flush. Optionally holds the HI/LO pair.

Parameters:
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- stall_mem  in  1  MEM stage stalled
- stall_wb  in  1  WB stage stalled
- flush  in  1  exception flush; kill the instruction entering WB
- mem_wd  in  AW  destination register
- mem_wreg  in  1  register write request
- mem_wdata  in  DW  ALU/result data
- mem_load_op  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 treated as none
- mem_addr_lo  in  2  load address bits [1:0]
- mem_rdata  in  DW  raw data-memory word
- mem_whilo  in  1  HI/LO write request
- mem_hi  in  DW  HI value
- mem_lo  in  DW  LO value
- wb_wd  out  AW  to register file write_addr
- wb_wreg  out  1  to register file we
- wb_wdata  out  DW  to register file write_instr
- wb_adel  out  1  misaligned-load flag, valid for the cycle the instruction sits in WB
- hi_o  out  DW  current HI, with bypass
- lo_o  out  DW  current LO, with bypass

Behaviour:
- Reset (async, rst=1): every output and internal register is 0, including HI/LO.
- Posedge update priority:
  - rst
  - flush → bubble
  - stall_mem=1 and stall_wb=0 → bubble
  - stall_mem=0 → capture
  - otherwise hold all registers
- Bubble: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_adel=0, internal wb_whilo=0.
- Latency: one cycle MEM→WB; register file writes on the following negedge.
- Load formatting applies only when load_op is LB..LW; wb_wdata is the formatted value and mem_wdata is ignored.
  - Byte lanes are big-endian: addr_lo 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
  - Halfwords: addr_lo 00→[31:16], 10→[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Misaligned load (LH/LHU with addr_lo[0]=1, or LW with addr_lo≠00): capture wb_wreg=0, wb_wdata=0, wb_adel=1. wb_wd still captured.
- wb_adel is a registered level; it clears on the next capture or bubble.
- Writes to r0 pass through unchanged; the register file discards them.
- A flush asserted together with a valid misaligned load: flush wins, wb_adel=0.
- HI/LO (feature on):
  - hi_r/lo_r load wb_hi/wb_lo at the posedge after a WB-stage instruction with wb_whilo=1, unless stall_wb=1.
  - hi_o/lo_o = wb_whilo ? wb_hi/wb_lo : hi_r/lo_r. This bypass resolves the MFHI-after-MTHI hazard.

Optional Feature:
- Macro WB_HILO_EN.
- Defined: HI/LO registers, capture pipeline and bypass as above.
- Undefined: mem_whilo/mem_hi/mem_lo ignored; hi_o=lo_o=0 constantly; no HI/LO flops synthesized. Ports remain for interface stability.

Decomposition:
- Shared define file gains:
  - load-op encodings: LOAD_NONE, LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LW
  - ZeroWord
  - existing RstEnable, WriteEnable, etc.
- One combinational sub-module, load_align: inputs load_op, addr_lo, rdata, wdata; outputs fmt_data, misalign.
- Stage and HI/LO logic stay in mem_wb_stage.

Test Plan:
- rst pulsed mid-cycle with a prior capture pending → all outputs 0 immediately, before the next clock edge.
- LB, addr_lo=01, rdata=0x12_F4_56_78, wd=3 → next cycle wb_wdata=0xFFFFFFF4, wb_wreg=1, wb_wd=3. Same with LBU → 0x000000F4.
- LW, addr_lo=10 → wb_adel=1, wb_wreg=0, wb_wdata=0. Next aligned ALU op (wdata=0x55) → wb_adel=0, wb_wdata=0x55.
- stall_mem=1, stall_wb=0 → bubble (wb_wreg=0). stall_mem=1, stall_wb=1 → outputs held 3 cycles. flush with a valid input → bubble.
- WB_HILO_EN: whilo=1, hi=0xA, lo=0xB → in the WB cycle hi_o=0xA via bypass; the following cycle hi_r=0xA. Without the macro → hi_o=lo_o=0 throughout.
